// File: rtl/sound_sched.sv
// sound_sched: prioritised sound request scheduler.
//
// Each requester strobes req_i[i] with a 3-bit code. The code is latched into a
// per-requester pending slot. One pending slot per cycle (lowest index first)
// moves into a FIFO. A small FSM drains the FIFO one sound at a time:
// IDLE -> ISSUE (one-cycle play_sound pulse) -> PLAY (DUR_CYCLES) ->
// GAP (GAP_CYCLES) -> IDLE.
//
// Optional feature: define SOUND_SCHED_PREEMPT_EN so that req_i[0] flushes the
// FIFO, drops the other pending slots and aborts the current sound. With the
// macro undefined, req_i[0] only wins the pending-slot arbitration.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   req_i        per-requester single-cycle request strobes
//   req_code_i   sound codes; slice i is [3i+2:3i], sampled with req_i[i]
//   sound_code_o code of the last issued sound (held until the next issue)
//   play_sound_o single-cycle pulse starting a sound
//   busy_o       pending slot set, FIFO non-empty or FSM not idle
//   q_count_o    number of FIFO entries
//   pending_o    per-requester latched-but-not-queued flags
//   overrun_o    one-cycle pulse when a still-pending code is overwritten
module sound_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned DUR_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_i,
  input  logic [3*NREQ-1:0]       req_code_i,
  output logic [2:0]              sound_code_o,
  output logic                    play_sound_o,
  output logic                    busy_o,
  output logic [$clog2(QDEPTH):0] q_count_o,
  output logic [NREQ-1:0]         pending_o,
  output logic                    overrun_o
);

  localparam int unsigned AW     = $clog2(QDEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned CntMax = (DUR_CYCLES > GAP_CYCLES) ? DUR_CYCLES : GAP_CYCLES;
  // Counter is loaded with (cycles - 1), so log2 of the larger value suffices.
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StPlay, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      sound_code_q;
  logic            play_q;

  logic [NREQ-1:0] pend_q, pend_d;
  logic [2:0]      code_q [NREQ];
  logic [2:0]      code_d [NREQ];
  logic            overrun_q, overrun_d;

  logic [2:0]      mem_q [QDEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            preempt, issue, full, found, push, wr_en;
  logic [NREQ-1:0] xfer_oh, leaving;
  logic [2:0]      push_code;

  always_comb begin
    preempt = 1'b0;
`ifdef SOUND_SCHED_PREEMPT_EN
    preempt = req_i[0];
`endif
    issue = (state_q == StIssue);
    full  = (count_q == CW'(QDEPTH));

    // Lowest set pending index wins the single transfer slot.
    found     = 1'b0;
    xfer_oh   = '0;
    push_code = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pend_q[i] && !found) begin
        found      = 1'b1;
        xfer_oh[i] = 1'b1;
        push_code  = code_q[i];
      end
    end
    // A pop on the same edge frees a slot even when full.
    push    = found && (!full || issue);
    leaving = push ? xfer_oh : '0;

    pend_d    = pend_q & ~leaving;
    code_d    = code_q;
    overrun_d = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_i[i]) begin
        // Re-request on the leaving edge is a fresh capture, not an overwrite.
        if (pend_q[i] && !leaving[i]) overrun_d = 1'b1;
        pend_d[i] = 1'b1;
        code_d[i] = req_code_i[3*i +: 3];
      end
    end
    if (preempt) pend_d = pend_d & NREQ'(1);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (preempt) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + AW'(1);
        wr_en  = 1'b1;
      end
      if (issue) rptr_d = rptr_q + AW'(1);
      case ({push, issue})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q    <= '0;
      code_q    <= '{default: '0};
      overrun_q <= 1'b0;
      mem_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      pend_q    <= pend_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      if (wr_en) mem_q[wptr_q] <= push_code;
    end
  end

  // Playback FSM with registered play_sound and sound_code.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sound_code_q <= '0;
      play_q       <= 1'b0;
    end else begin
      play_q <= 1'b0;
      if (preempt) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (count_q != '0) begin
              state_q      <= StIssue;
              play_q       <= 1'b1;
              sound_code_q <= mem_q[rptr_q];
            end
          end
          StIssue: begin
            state_q <= StPlay;
            cnt_q   <= CntW'(DUR_CYCLES - 1);
          end
          StPlay: begin
            if (cnt_q == '0) begin
              state_q <= StGap;
              cnt_q   <= CntW'(GAP_CYCLES - 1);
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StGap: begin
            if (cnt_q == '0) state_q <= StIdle;
            else             cnt_q   <= cnt_q - CntW'(1);
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sound_code_o = sound_code_q;
  assign play_sound_o = play_q;
  assign busy_o       = (|pend_q) || (count_q != '0) || (state_q != StIdle);
  assign q_count_o    = count_q;
  assign pending_o    = pend_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_sound_sched.sv
// Self-checking bench for sound_sched (NREQ=4, QDEPTH=4, DUR=10, GAP=3).
// Covers the latency table, fixed corner sequences and a randomized run
// compared cycle by cycle against a queue-based scheduler model.
module tb_sound_sched;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned DUR    = 10;
  localparam int unsigned GAP    = 3;
  localparam int          SPACE  = DUR + GAP + 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [3*NREQ-1:0] req_code = '0;
  logic [2:0]        sound_code;
  logic              play_sound;
  logic              busy;
  logic [2:0]        q_count;
  logic [NREQ-1:0]   pending;
  logic              overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int         t;
    logic [2:0] code;
  } play_t;
  play_t plays[$];
  int    ov_cnt = 0;

  typedef struct {
    int              idx;
    logic [2:0]      code;
    logic [NREQ-1:0] exp_pend;
  } lat_vec_t;
  lat_vec_t vecs[5];

  // Reference model: pending slots, FIFO queue and the cycle the player is free.
  bit         m_pend [NREQ];
  logic [2:0] m_code [NREQ];
  logic [2:0] m_q [$];
  bit         m_issue;
  bit         m_ov;
  logic [2:0] m_sound;
  int         m_next_idle;
  int         m_t;

  logic [12:0]     exp_vec;
  logic [NREQ-1:0] m_pend_v;
  logic [NREQ-1:0] rreq;
  logic [3*NREQ-1:0] rcode;
  logic [7:0]      mask;
  int              t0;

  sound_sched #(
    .NREQ      (NREQ),
    .QDEPTH    (QDEPTH),
    .DUR_CYCLES(DUR),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_i       (req),
    .req_code_i  (req_code),
    .sound_code_o(sound_code),
    .play_sound_o(play_sound),
    .busy_o      (busy),
    .q_count_o   (q_count),
    .pending_o   (pending),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && play_sound) begin
      play_t p;
      p.t    = cyc;
      p.code = sound_code;
      plays.push_back(p);
    end
    if (rstn && overrun) ov_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse(input int idx, input logic [2:0] code);
    req = '0;
    req[idx] = 1'b1;
    req_code[3*idx +: 3] = code;
    tick();
    req = '0;
  endtask

  task automatic queue_codes(input int idx, input int n, input logic [11:0] codes);
    for (int k = 0; k < n; k++) begin
      req = '0;
      req[idx] = 1'b1;
      req_code[3*idx +: 3] = codes[3*k +: 3];
      tick();
    end
    req = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    tick();
    tick();
    rstn = 1'b1;
    plays.delete();
    ov_cnt = 0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_code"}, sound_code, 0);
    chk({name, "_play"}, play_sound, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_qcnt"}, q_count, 0);
    chk({name, "_pend"}, pending, 0);
    chk({name, "_ovr"}, overrun, 0);
  endtask

  task automatic wait_play(input string name);
    int n = 0;
    while (!play_sound && n < 100) begin
      tick();
      n++;
    end
    if (!play_sound) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: play_sound=0 after 100 cycles, want 1", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: busy=1 after 200 cycles, want 0", name);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      m_pend[i] = 1'b0;
      m_code[i] = '0;
    end
    m_q.delete();
    m_issue     = 1'b0;
    m_ov        = 1'b0;
    m_sound     = '0;
    m_next_idle = 0;
    m_t         = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [3*NREQ-1:0] rc);
    int sel;
    bit push;
    bit pop;
    bit nxt_issue;
    bit pre;
    pop = m_issue;
    sel = -1;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (m_pend[i]) begin
        sel = i;
        break;
      end
    end
    push = (sel >= 0) && ((m_q.size() < int'(QDEPTH)) || pop);
    pre = 1'b0;
`ifdef SOUND_SCHED_PREEMPT_EN
    pre = r[0];
`endif
    nxt_issue = !pre && !m_issue && (m_t >= m_next_idle) && (m_q.size() > 0);
    if (nxt_issue) begin
      m_sound     = m_q[0];
      m_next_idle = m_t + 2 + int'(DUR) + int'(GAP);
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(m_code[sel]);
      m_pend[sel] = 1'b0;
    end
    m_ov = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (r[i]) begin
        if (m_pend[i]) m_ov = 1'b1;
        m_pend[i] = 1'b1;
        m_code[i] = rc[3*i +: 3];
      end
    end
    if (pre) begin
      m_q.delete();
      for (int i = 1; i < int'(NREQ); i++) m_pend[i] = 1'b0;
      m_next_idle = m_t + 1;
    end
    m_issue = nxt_issue;
    m_t++;
  endtask

  initial begin
    vecs[0] = '{2, 3'd5, 4'b0100};
    vecs[1] = '{0, 3'd3, 4'b0001};
    vecs[2] = '{3, 3'd7, 4'b1000};
    vecs[3] = '{1, 3'd6, 4'b0010};
    vecs[4] = '{2, 3'd0, 4'b0100};

    // Reset values while rstn is held low.
    tick();
    chk_reset_vals("reset");
    do_reset();

    // Single-request latency table.
    for (int v = 0; v < 5; v++) begin
      plays.delete();
      pulse(vecs[v].idx, vecs[v].code);
      chk("lat_pend1", pending, vecs[v].exp_pend);
      chk("lat_q1", q_count, 0);
      tick();
      chk("lat_q2", q_count, 1);
      chk("lat_pend2", pending, 0);
      chk("lat_play2", play_sound, 0);
      tick();
      chk("lat_play3", play_sound, 1);
      chk("lat_code3", sound_code, vecs[v].code);
      tick();
      chk("lat_play4", play_sound, 0);
      chk("lat_q4", q_count, 0);
      repeat (12) tick();
      chk("lat_busy16", busy, 1);
      repeat (2) tick();
      chk("lat_busy18", busy, 0);
      chk("lat_hold18", sound_code, vecs[v].code);
      chk("lat_nplays", plays.size(), 1);
    end

    // Two simultaneous requests: priority order and issue spacing.
    do_reset();
    t0 = cyc;
    req = 4'b1010;
    req_code[5:3]  = 3'd2;
    req_code[11:9] = 3'd7;
    tick();
    req = '0;
    repeat (45) tick();
    chk("pair_nplays", plays.size(), 2);
    if (plays.size() >= 1) begin
      chk("pair_t0", plays[0].t - t0, 3);
      chk("pair_c0", plays[0].code, 2);
    end
    if (plays.size() >= 2) begin
      chk("pair_t1", plays[1].t - t0, 3 + SPACE);
      chk("pair_c1", plays[1].code, 7);
    end

    // Full FIFO during PLAY; a later request waits in its pending slot.
    do_reset();
    pulse(3, 3'd0);
    wait_play("full_first");
    tick();
    queue_codes(1, 4, {3'd4, 3'd3, 3'd2, 3'd1});
    tick();
    tick();
    chk("full_q4", q_count, 4);
    pulse(2, 3'd6);
    chk("full_pend2a", pending[2], 1);
    tick();
    chk("full_pend2b", pending[2], 1);
    chk("full_q4b", q_count, 4);
    wait_play("full_issue");
    chk("full_code1", sound_code, 1);
    tick();
    chk("full_q_after", q_count, 4);
    chk("full_pend2_after", pending[2], 0);
    for (int k = 0; k < 4; k++) begin
      logic [11:0] ord;
      ord = {3'd6, 3'd4, 3'd3, 3'd2};
      wait_play("full_order");
      chk("full_order", sound_code, ord[3*k +: 3]);
      tick();
    end
    chk("full_no_ovr", ov_cnt, 0);

    // Overwrite of a pending code while the FIFO is full.
    do_reset();
    pulse(3, 3'd0);
    wait_play("ovr_first");
    tick();
    queue_codes(1, 4, {3'd4, 3'd3, 3'd2, 3'd1});
    tick();
    tick();
    pulse(1, 3'd3);
    pulse(1, 3'd6);
    chk("ovr_pulse", overrun, 1);
    tick();
    chk("ovr_once", overrun, 0);
    for (int k = 0; k < 5; k++) begin
      logic [14:0] ord;
      ord = {3'd6, 3'd4, 3'd3, 3'd2, 3'd1};
      wait_play("ovr_order");
      chk("ovr_order", sound_code, ord[3*k +: 3]);
      tick();
    end
    wait_idle("ovr_idle");
    chk("ovr_nplays", plays.size(), 6);
    chk("ovr_cnt", ov_cnt, 1);

    // req[0] while a sound plays with three codes queued.
    do_reset();
    pulse(3, 3'd7);
    wait_play("pre_first");
    tick();
    queue_codes(1, 3, {3'd0, 3'd4, 3'd3, 3'd2});
    tick();
    tick();
    chk("pre_q3", q_count, 3);
    pulse(0, 3'd1);
`ifdef SOUND_SCHED_PREEMPT_EN
    chk("pre_flush", q_count, 0);
    chk("pre_pend", pending, 4'b0001);
    tick();
    tick();
    chk("pre_play3", play_sound, 1);
    chk("pre_code3", sound_code, 1);
    wait_idle("pre_idle");
    chk("pre_nplays", plays.size(), 2);
`else
    chk("nopre_q", q_count, 3);
    chk("nopre_pend", pending, 4'b0001);
    tick();
    wait_play("nopre_next");
    if (plays.size() >= 1) chk("nopre_space", cyc - plays[0].t, SPACE);
    // Queued FIFO entries keep their order; all four codes issue once each.
    mask = '0;
    mask[sound_code] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      wait_play("nopre_rest");
      mask[sound_code] = 1'b1;
    end
    wait_idle("nopre_idle");
    chk("nopre_set", mask, 8'b0001_1110);
    chk("nopre_nplays", plays.size(), 5);
`endif

    // Reset mid-PLAY with two entries queued.
    do_reset();
    pulse(3, 3'd7);
    wait_play("rst_first");
    tick();
    queue_codes(1, 2, {3'd0, 3'd0, 3'd2, 3'd1});
    repeat (3) tick();
    chk("rst_q2", q_count, 2);
    rstn = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    tick();
    tick();
    chk_reset_vals("rst_hold");
    rstn = 1'b1;
    plays.delete();
    repeat (40) tick();
    chk("rst_nplays", plays.size(), 0);
    chk("rst_busy", busy, 0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    repeat (1500) begin
      for (int i = 0; i < int'(NREQ); i++) m_pend_v[i] = m_pend[i];
      exp_vec = {m_issue, m_sound,
                 (|m_pend_v) || (m_q.size() > 0) || (m_t < m_next_idle),
                 3'(m_q.size()), m_pend_v, m_ov};
      chk("random", {play_sound, sound_code, busy, q_count, pending, overrun}, exp_vec);
      for (int i = 0; i < int'(NREQ); i++) begin
        if (i == 0) rreq[i] = ($urandom_range(0, 47) == 0);
        else        rreq[i] = ($urandom_range(0, 15) == 0);
      end
      rcode    = 12'($urandom);
      req      = rreq;
      req_code = rcode;
      model_step(rreq, rcode);
      tick();
    end
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
